sma_result_drain: RTL and testbench
===================================

# sma_result_drain

Downstream of the SMA load/run sequencer: once the sequencer enters its result-read state and sweeps RADR upward every cycle, this block captures the first NWORDS result words returned by the SMA, then drains them off-chip over a narrow byte-wide valid/ack port. A trailing XOR checksum byte closes the transfer. The sequencer has no backpressure, so capture is single-pass and drain is fully decoupled through an internal buffer.

## Interface
Parameters:
- DW, 32, result word width; multiple of 8
- NWORDS, 16, words captured (2..128); RADR values >= NWORDS ignored

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- STAT  in  16  sequencer one-hot state; STAT[8] = result-read state
- RADR  in  7  result address driven by sequencer
- RDATA  in  DW  SMA read data; data for address A valid one cycle after A is presented
- DOUT  out  8  output byte
- DOUT_VALID  out  1  DOUT holds a byte to transfer
- DOUT_ACK  in  1  receiver accepts; transfer = VALID & ACK at a rising edge
- BUSY  out  1  high in CAPTURE or DRAIN
- READ_DONE  out  1  sticky: all bytes plus checksum transferred

## Operation
- Pipeline: every edge, rd_q <= STAT[8], radr_q <= RADR. Write mem[radr_q] <= RDATA when rd_q & (radr_q < NWORDS) & state==CAPTURE.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: STAT[8] sampled 1 -> CAPTURE; clear capture count and checksum.
- CAPTURE: count writes; when write of address NWORDS-1 occurs -> DRAIN. STAT[8] sampled 0 before completion -> IDLE, buffer discarded, no output.
- DRAIN: bytes sent word 0..NWORDS-1, each word LSB byte first (DW/8 bytes per word), then one checksum byte = XOR of all data bytes sent. DOUT_VALID high throughout DRAIN; DOUT/VALID held stable until ACK. On transfer, checksum accumulates the data byte, byte index advances, next byte on DOUT the following cycle (back-to-back transfers allowed with ACK held high). Transfer of checksum byte -> DONE.
- DONE: READ_DONE=1, VALID=0; held until reset (STAT ignored).
- Byte index width ceil(log2(NWORDS*DW/8+1)); no wrap; checksum 8-bit XOR, no carries.
- DOUT_ACK while VALID=0 ignored. RADR repeating or non-monotonic: later write to same address overwrites; completion still triggered only by address NWORDS-1 write.

## Timing
- Reset values: DOUT=0, DOUT_VALID=0, BUSY=0, READ_DONE=0, state IDLE, rd_q=0, radr_q=0, checksum=0. Buffer contents not reset.
- Entry: STAT[8] rises at edge t0 (RADR=0 that cycle) -> state CAPTURE after edge t0; word 0 written at edge t0+1; word NWORDS-1 written at t0+NWORDS.
- First byte: DOUT_VALID=1 from the cycle after edge t0+NWORDS.
- With ACK tied high: NWORDS*DW/8+1 transfers on consecutive edges; READ_DONE rises the cycle after last transfer.
- BUSY combinational from state; DOUT, DOUT_VALID, READ_DONE registered.
- Reset asserted mid-CAPTURE or mid-DRAIN: immediate return to reset values; nothing resumes.

## Test plan
- Nominal, DW=32, NWORDS=4, RDATA for address A = 32'h0A0B0C00|A, ACK high: 17 bytes 00,0C,0B,0A,01,0C,0B,0A,02,...,03,0C,0B,0A, checksum 8'h00; READ_DONE 1 cycle after last.
- Latency: STAT[8] rise at edge t0 -> first DOUT_VALID cycle after edge t0+4; BUSY high from after t0.
- Backpressure: ACK toggled 1-0-0-1 pattern and random: DOUT stable while VALID & !ACK, no byte lost or duplicated; same sequence as nominal.
- Abort: STAT[8] drops after 2 words captured -> IDLE, DOUT_VALID never asserted; re-entry captures fresh data and drains correctly.
- Out-of-range: RADR sweeps to 10 with NWORDS=4 -> addresses 4..10 ignored, output identical to nominal; READ_DONE stays 1 while STAT[8] re-toggles.
- Reset mid-drain after 5 transfers: all outputs to reset values next cycle; a new read sweep yields full correct 17-byte sequence.

Source files
------------

// File: rtl/sma_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : sma_result_drain
//  Purpose  : Captures the first NWORDS result words swept out of the SMA
//             during the sequencer's result-read state, then drains them as
//             bytes (LSB first) over a valid/ack port, closed by an XOR
//             checksum byte.
//  Revision : 1.0  initial release
// ============================================================================
module sma_result_drain #(
  parameter int DW     = 32,
  parameter int NWORDS = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [15:0]   STAT,
  input  logic [6:0]    RADR,
  input  logic [DW-1:0] RDATA,
  output logic [7:0]    DOUT,
  output logic          DOUT_VALID,
  input  logic          DOUT_ACK,
  output logic          BUSY,
  output logic          READ_DONE
);

  localparam int BPW    = DW / 8;
  localparam int NBYTES = NWORDS * BPW;
  localparam int BW     = $clog2(NBYTES + 1);
  localparam int AW     = $clog2(NWORDS);

  localparam logic [BW-1:0] C_NBYTES = BW'(NBYTES);
  localparam logic [BW-1:0] C_BPW    = BW'(BPW);
  localparam logic [7:0]    C_NWORDS = 8'(NWORDS);
  localparam logic [7:0]    C_LAST   = 8'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rd;
  logic [6:0]      r_radr;
  logic [DW-1:0]   r_mem [NWORDS];
  logic [7:0]      r_dout;
  logic            r_valid;
  logic            r_done;
  logic [7:0]      r_csum;
  logic [BW-1:0]   r_bidx;

  logic            w_wr;
  logic            w_last_wr;
  logic            w_xfer;
  logic [BW-1:0]   w_nxt_idx;
  logic [AW-1:0]   w_widx;
  logic [BW-1:0]   w_bsel;
  logic [DW-1:0]   w_word;
  logic [7:0]      w_byte;
  logic            w_stat_unused;

  // Only the result-read bit of the sequencer state matters here.
  assign w_stat_unused = ^{STAT[15:9], STAT[7:0]};

  // A write lands only while capturing, for the registered in-range address.
  assign w_wr      = (r_state == S_CAPTURE) && r_rd && ({1'b0, r_radr} < C_NWORDS);
  assign w_last_wr = w_wr && ({1'b0, r_radr} == C_LAST);
  assign w_xfer    = (r_state == S_DRAIN) && r_valid && DOUT_ACK;

  // Locate the byte that follows the one currently on DOUT.
  assign w_nxt_idx = r_bidx + BW'(1);
  assign w_widx    = AW'(w_nxt_idx / C_BPW);
  assign w_bsel    = w_nxt_idx % C_BPW;
  assign w_word    = r_mem[w_widx];
  assign w_byte    = 8'(w_word >> {w_bsel, 3'b000});

  // State register and the one-cycle address/read-state pipeline.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_rd    <= 1'b0;
      r_radr  <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rd    <= STAT[8];
      r_radr  <= RADR;
    end
  end

  // Next-state logic; completing the last word wins over a dropped read state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (STAT[8]) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (w_last_wr)     w_state_nxt = S_DRAIN;
        else if (!STAT[8]) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (w_xfer && (r_bidx == C_NBYTES)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result buffer: not reset, overwritten by every capture pass.
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_radr[AW-1:0]] <= RDATA;
  end

  // Drain datapath: byte presentation, index, running checksum, done flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dout  <= 8'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_csum  <= 8'd0;
      r_bidx  <= '0;
    end else begin
      if ((r_state == S_IDLE) && STAT[8]) begin
        r_csum <= 8'd0;
        r_bidx <= '0;
      end
      if (w_last_wr) begin
        r_dout  <= r_mem[0][7:0];
        r_valid <= 1'b1;
      end
      if (w_xfer) begin
        if (r_bidx == C_NBYTES) begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
          r_dout  <= 8'd0;
        end else begin
          r_bidx <= w_nxt_idx;
          r_csum <= r_csum ^ r_dout;
          if (w_nxt_idx == C_NBYTES) r_dout <= r_csum ^ r_dout;
          else                       r_dout <= w_byte;
        end
      end
    end
  end

  assign DOUT       = r_dout;
  assign DOUT_VALID = r_valid;
  assign READ_DONE  = r_done;
  assign BUSY       = (r_state == S_CAPTURE) || (r_state == S_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_sma_result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sma_result_drain
//  Purpose  : Self-checking bench for sma_result_drain (DW=32, NWORDS=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sma_result_drain;

  localparam int NW = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] STAT = 16'h0;
  logic [6:0]  RADR = 7'd0;
  logic [31:0] RDATA = 32'h0;
  logic [7:0]  DOUT;
  logic        DOUT_VALID;
  logic        DOUT_ACK = 1'b0;
  logic        BUSY;
  logic        READ_DONE;

  always #5 CLK = ~CLK;

  sma_result_drain #(.DW(32), .NWORDS(NW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .STAT       (STAT),
    .RADR       (RADR),
    .RDATA      (RDATA),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_ACK   (DOUT_ACK),
    .BUSY       (BUSY),
    .READ_DONE  (READ_DONE)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         nbytes = 0;
  logic [7:0] last_byte = 8'h0;
  bit         mon_en = 1'b0;
  int         ack_mode = 0;

  typedef struct {
    int         mode;
    int         ack;
    int         radr_end;
    int         exp_bytes;
    logic [7:0] exp_csum;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] fdata(int mode, int a);
    if (mode == 0) return 32'h0A0B0C00 | 32'(a);
    return 32'(a) * 32'h11111111 + 32'd1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every accepted byte is popped and compared; stalled bytes must hold.
  task automatic monitor();
    logic       prev_stall;
    logic [7:0] prev_dout;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_dout  = 8'h0;
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {31'b0, DOUT_VALID}, 32'd1);
          chk("hold_dout", {24'b0, DOUT}, {24'b0, prev_dout});
        end
        if (DOUT_VALID && DOUT_ACK) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %0h expected no transfer", DOUT);
          end else begin
            e = exp_q.pop_front();
            chk("byte", {24'b0, DOUT}, {24'b0, e});
          end
          nbytes++;
          last_byte = DOUT;
        end
        prev_stall = DOUT_VALID && !DOUT_ACK;
        prev_dout  = DOUT;
      end
    end
  endtask

  task automatic ack_drv();
    int cnt;
    cnt = 0;
    forever begin
      @(posedge CLK);
      #1;
      case (ack_mode)
        0:       DOUT_ACK = 1'b1;
        1:       DOUT_ACK = ((cnt % 4) == 0) || ((cnt % 4) == 3);
        2:       DOUT_ACK = 1'($urandom_range(0, 1));
        default: DOUT_ACK = 1'b0;
      endcase
      cnt++;
    end
  endtask

  task automatic push_expected(int mode);
    logic [31:0] d;
    logic [7:0]  cs;
    cs = 8'h0;
    for (int w = 0; w < NW; w++) begin
      d = fdata(mode, w);
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(d[8*b +: 8]);
        cs = cs ^ d[8*b +: 8];
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    RST_N  = 1'b0;
    STAT   = 16'h0;
    RADR   = 7'd0;
    RDATA  = 32'h0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_dout",  {24'b0, DOUT}, 32'h0);
    chk("rst_valid", {31'b0, DOUT_VALID}, 32'h0);
    chk("rst_busy",  {31'b0, BUSY}, 32'h0);
    chk("rst_done",  {31'b0, READ_DONE}, 32'h0);
    @(posedge CLK);
    #1;
    RST_N  = 1'b1;
    nbytes = 0;
    mon_en = 1'b1;
  endtask

  // Sequencer model: RADR sweeps 0..radr_end, RDATA follows one cycle later.
  task automatic sweep(int mode, int radr_end);
    @(posedge CLK);
    #1;
    STAT = 16'h0100;
    RADR = 7'd0;
    for (int a = 1; a <= radr_end; a++) begin
      @(posedge CLK);
      #1;
      RADR  = 7'(a);
      RDATA = fdata(mode, a - 1);
    end
    @(posedge CLK);
    #1;
    RADR  = 7'd0;
    RDATA = fdata(mode, radr_end);
    @(posedge CLK);
    #1;
    STAT = 16'h0;
  endtask

  task automatic wait_done(string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (READ_DONE) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got READ_DONE=0 expected 1 within 300 cycles", name);
    end
  endtask

  initial begin
    int seen_v;
    bit hit;

    vecs[0] = '{mode: 0, ack: 0, radr_end: 3,  exp_bytes: 17, exp_csum: 8'h00};
    vecs[1] = '{mode: 0, ack: 1, radr_end: 3,  exp_bytes: 17, exp_csum: 8'h00};
    vecs[2] = '{mode: 0, ack: 2, radr_end: 3,  exp_bytes: 17, exp_csum: 8'h00};
    vecs[3] = '{mode: 0, ack: 0, radr_end: 10, exp_bytes: 17, exp_csum: 8'h00};
    vecs[4] = '{mode: 1, ack: 2, radr_end: 3,  exp_bytes: 17, exp_csum: 8'h04};
    vecs[5] = '{mode: 1, ack: 1, radr_end: 10, exp_bytes: 17, exp_csum: 8'h04};

    fork
      monitor();
      ack_drv();
    join_none

    // Table-driven transfers, followed by STAT re-toggling while DONE.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ack_mode = vecs[i].ack;
      push_expected(vecs[i].mode);
      sweep(vecs[i].mode, vecs[i].radr_end);
      wait_done("vec");
      chk("vec_nbytes", 32'(nbytes), 32'(vecs[i].exp_bytes));
      chk("vec_csum", {24'b0, last_byte}, {24'b0, vecs[i].exp_csum});
      chk("vec_q_empty", 32'(exp_q.size()), 32'd0);
      repeat (3) begin
        @(posedge CLK); #1; STAT = 16'h0100;
        @(posedge CLK); #1; STAT = 16'h0;
      end
      @(negedge CLK);
      chk("done_sticky", {31'b0, READ_DONE}, 32'd1);
      chk("done_valid",  {31'b0, DOUT_VALID}, 32'd0);
      chk("done_busy",   {31'b0, BUSY}, 32'd0);
    end

    // Latency: STAT[8] sampled at t0, VALID after t0+4, READ_DONE after t0+21.
    do_reset();
    ack_mode = 0;
    push_expected(0);
    STAT  = 16'h0100;
    RADR  = 7'd0;
    RDATA = 32'h0;
    @(negedge CLK);
    chk("lat_busy_pre", {31'b0, BUSY}, 32'd0);
    for (int k = 0; k <= 22; k++) begin
      @(posedge CLK);
      #1;
      STAT  = (k <= 3) ? 16'h0100 : 16'h0;
      RADR  = (k + 1 <= 3) ? 7'(k + 1) : 7'd0;
      RDATA = (k <= 3) ? fdata(0, k) : 32'h0;
      @(negedge CLK);
      chk("lat_busy",  {31'b0, BUSY}, 32'(k <= 20));
      chk("lat_valid", {31'b0, DOUT_VALID}, 32'((k >= 4) && (k <= 20)));
      chk("lat_done",  {31'b0, READ_DONE}, 32'(k >= 21));
    end
    chk("lat_nbytes", 32'(nbytes), 32'd17);
    chk("lat_q_empty", 32'(exp_q.size()), 32'd0);

    // Abort after two captured words, then a fresh capture.
    do_reset();
    ack_mode = 0;
    STAT = 16'h0100;
    RADR = 7'd0;
    @(posedge CLK); #1; RADR = 7'd1; RDATA = fdata(1, 0);
    @(posedge CLK); #1; RADR = 7'd2; RDATA = fdata(1, 1);
    @(posedge CLK); #1; STAT = 16'h0; RADR = 7'd0; RDATA = fdata(1, 2);
    seen_v = 0;
    repeat (12) begin
      @(negedge CLK);
      if (DOUT_VALID) seen_v++;
    end
    chk("abort_valid_seen", 32'(seen_v), 32'd0);
    chk("abort_busy", {31'b0, BUSY}, 32'd0);
    push_expected(1);
    sweep(1, 3);
    wait_done("reentry");
    chk("reentry_nbytes", 32'(nbytes), 32'd17);
    chk("reentry_csum", {24'b0, last_byte}, 32'h04);
    chk("reentry_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset asserted after five transfers, then a full clean pass.
    do_reset();
    ack_mode = 0;
    push_expected(0);
    sweep(0, 3);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      if (nbytes >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL midrst_timeout: got %0d transfers expected 5", nbytes);
    end
    #1;
    RST_N  = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    chk("midrst_count", 32'(nbytes), 32'd5);
    chk("midrst_dout",  {24'b0, DOUT}, 32'h0);
    chk("midrst_valid", {31'b0, DOUT_VALID}, 32'h0);
    chk("midrst_busy",  {31'b0, BUSY}, 32'h0);
    chk("midrst_done",  {31'b0, READ_DONE}, 32'h0);
    @(posedge CLK);
    #1;
    RST_N  = 1'b1;
    nbytes = 0;
    mon_en = 1'b1;
    push_expected(0);
    sweep(0, 3);
    wait_done("after_rst");
    chk("after_rst_nbytes", 32'(nbytes), 32'd17);
    chk("after_rst_csum", {24'b0, last_byte}, 32'h00);
    chk("after_rst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
